adc_init_seq: RTL and testbench

ADC power-up configuration sequencer, directly upstream of the ADC SPI control-word serializer. Holds a host-written table of up to 16 24-bit control words (R/W bit, 7-bit address, 16-bit data). On a start request it:
- pulses the ADC hardware reset,
- waits for the ADC to settle,
- hands each table word to the serializer in order with a load strobe, handshaking on the serializer busy flag.

It replaces host-driven, word-by-word loading of control words during bring-up.

---
 rtl/adc_init_seq.sv | 213 +++++++++++++++++++++
 tb/tb_adc_init_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_init_seq.sv
// -----------------------------------------------------------------------------
// adc_init_seq
//
// ADC power-up configuration sequencer. Holds a host-written table of up to
// sixteen 24-bit control words ({R/W, addr[6:0], data[15:0]}). On a start
// request it pulses the ADC hardware reset, waits for the ADC to settle, then
// hands each table word to the SPI control-word serializer in order with a
// one-cycle load strobe, handshaking on the serializer busy flag.
//
// Optional feature (compile-time macro ADC_INIT_AUTOSTART_EN):
//   defined   - one internal start is issued on the first clock edge after
//               rstn deasserts, using cfg_num at that edge.
//   undefined - the sequence only runs on an external start pulse.
//
// Ports:
//   adc_set_clk   in   1   sequencer clock (shared with the serializer)
//   rstn          in   1   asynchronous active-low reset
//   start         in   1   one-cycle run request (ignored while busy)
//   tbl_we        in   1   table write strobe (honoured only in IDLE)
//   tbl_addr      in   4   table write address
//   tbl_wdata     in  24   table write data
//   cfg_num       in   5   words to send, sampled at start, clamped to 16
//   spi_busy      in   1   serializer busy while shifting a word
//   adc_rstn_out  out  1   ADC hardware reset, active low
//   ctrl_word     out 24   word presented to the serializer
//   ctrl_load     out  1   one-cycle load strobe to the serializer
//   busy          out  1   high whenever the sequencer is not IDLE
//   done          out  1   one-cycle pulse on successful completion
//   err           out  1   sticky busy-wait timeout, cleared by next start
// -----------------------------------------------------------------------------
module adc_init_seq #(
    parameter int RST_PULSE_CYC = 100,
    parameter int RST_WAIT_CYC  = 1000,
    parameter int WORD_GAP_CYC  = 40,
    parameter int TIMEOUT_CYC   = 4096
) (
    input  logic        adc_set_clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        tbl_we,
    input  logic [3:0]  tbl_addr,
    input  logic [23:0] tbl_wdata,
    input  logic [4:0]  cfg_num,
    input  logic        spi_busy,
    output logic        adc_rstn_out,
    output logic [23:0] ctrl_word,
    output logic        ctrl_load,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, RST_LO, RST_WAIT, LOAD, WAIT_HI, WAIT_LO, GAP, FIN
    } state_t;

    // Each counter only has to reach its own parameter value.
    localparam int RST_W  = $clog2(RST_PULSE_CYC + 1);
    localparam int WAIT_W = $clog2(RST_WAIT_CYC + 1);
    localparam int GAP_W  = $clog2(WORD_GAP_CYC + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    state_t            state;
    state_t            next_state;
    logic [RST_W-1:0]  rst_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [3:0]        index;
    logic [3:0]        load_idx;
    logic [4:0]        num_q;
    logic              err_q;
    logic [23:0]       word_q;
    logic [23:0]       tbl [16];

    logic start_eff;
    logic accept;
    logic rst_done;
    logic wait_done;
    logic gap_done;
    logic timeout;
    logic last_word;
    logic in_busy_wait;

`ifdef ADC_INIT_AUTOSTART_EN
    // High only during reset and the first cycle after it, giving exactly
    // one internal start request on the first edge after rstn deasserts.
    logic auto_start;

    always_ff @(posedge adc_set_clk or negedge rstn) begin
        if (!rstn) auto_start <= 1'b1;
        else       auto_start <= 1'b0;
    end

    assign start_eff = start | auto_start;
`else
    assign start_eff = start;
`endif

    assign accept       = (state == IDLE) && start_eff;
    assign rst_done     = (rst_cnt  == RST_W'(RST_PULSE_CYC - 1));
    assign wait_done    = (wait_cnt == WAIT_W'(RST_WAIT_CYC - 1));
    assign gap_done     = (gap_cnt  == GAP_W'(WORD_GAP_CYC - 1));
    assign timeout      = (to_cnt   == TO_W'(TIMEOUT_CYC - 1));
    assign last_word    = (({1'b0, index} + 5'd1) == num_q);
    assign in_busy_wait = (state == WAIT_HI) || (state == WAIT_LO);

    // Entering LOAD from GAP happens on the same edge that advances index,
    // so the word fetched must already be the next one.
    assign load_idx = (state == GAP) ? (index + 4'd1) : index;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge adc_set_clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start_eff) next_state = RST_LO;
            RST_LO:   if (rst_done)  next_state = RST_WAIT;
            RST_WAIT: if (wait_done) next_state = (num_q == 5'd0) ? FIN : LOAD;
            LOAD:     next_state = WAIT_HI;
            WAIT_HI: begin
                if (spi_busy)     next_state = WAIT_LO;
                else if (timeout) next_state = IDLE;
            end
            WAIT_LO: begin
                if (!spi_busy)    next_state = GAP;
                else if (timeout) next_state = IDLE;
            end
            GAP:      if (gap_done)  next_state = last_word ? FIN : LOAD;
            FIN:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs decoded from the current state only, so an asynchronous reset
    // (state forced to IDLE) returns them to their idle values at once.
    // ---------------------------------------------------------------------
    always_comb begin
        adc_rstn_out = 1'b1;
        ctrl_load    = 1'b0;
        done         = 1'b0;
        busy         = (state != IDLE);
        case (state)
            RST_LO:  adc_rstn_out = 1'b0;
            LOAD:    ctrl_load    = 1'b1;
            FIN:     done         = 1'b1;
            default: ;
        endcase
    end

    assign ctrl_word = word_q;
    assign err       = err_q;

    // ---------------------------------------------------------------------
    // Counters and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge adc_set_clk or negedge rstn) begin
        if (!rstn) begin
            rst_cnt  <= '0;
            wait_cnt <= '0;
            gap_cnt  <= '0;
            to_cnt   <= '0;
            index    <= '0;
            num_q    <= '0;
            err_q    <= 1'b0;
            word_q   <= '0;
        end else begin
            // Counters run only while their state is held and clear on any
            // transition, so each state entry starts counting from zero.
            rst_cnt  <= (state == RST_LO   && next_state == RST_LO)   ? rst_cnt  + 1'b1 : '0;
            wait_cnt <= (state == RST_WAIT && next_state == RST_WAIT) ? wait_cnt + 1'b1 : '0;
            gap_cnt  <= (state == GAP      && next_state == GAP)      ? gap_cnt  + 1'b1 : '0;
            to_cnt   <= (in_busy_wait      && next_state == state)    ? to_cnt   + 1'b1 : '0;

            if (accept) begin
                err_q <= 1'b0;
                index <= '0;
                num_q <= (cfg_num > 5'd16) ? 5'd16 : cfg_num;
            end else if (in_busy_wait && next_state == IDLE) begin
                err_q <= 1'b1;
            end

            if (state == GAP && gap_done) index <= index + 4'd1;

            // Registered on entry so the word is valid alongside ctrl_load.
            if (next_state == LOAD) word_q <= tbl[load_idx];
        end
    end

    // ---------------------------------------------------------------------
    // Control-word table
    // ---------------------------------------------------------------------
    // NOTE: the table is plain storage with no reset, so it keeps the host's
    // contents across a sequencer reset and maps onto RAM/LUT memory.
    always_ff @(posedge adc_set_clk) begin
        if (tbl_we && state == IDLE) tbl[tbl_addr] <= tbl_wdata;
    end

endmodule

// File: tb/tb_adc_init_seq.sv
// -----------------------------------------------------------------------------
// tb_adc_init_seq
//
// Directed bench for adc_init_seq with short parameters (4/10/3/50). A small
// serializer model raises spi_busy two cycles after each load and holds it
// for 20 cycles. A monitor logs loads, done pulses and reset-low cycles;
// expected words come from a bench-side shadow of the table and expected
// timing from the parameter values.
// -----------------------------------------------------------------------------
module tb_adc_init_seq;

    localparam int P_RST  = 4;
    localparam int P_WAIT = 10;
    localparam int P_GAP  = 3;
    localparam int P_TO   = 50;

    localparam int SER_DLY  = 2;
    localparam int SER_HOLD = 20;

    // Start sampled at edge S: RST_LO cycles S..S+P_RST-1, RST_WAIT for
    // P_WAIT cycles, first LOAD in cycle S+P_RST+P_WAIT.
    localparam int FIRST   = P_RST + P_WAIT;
    // busy rises SER_DLY cycles after the load cycle, falls SER_HOLD later,
    // is seen low one edge after that, then P_GAP gap cycles.
    localparam int SPACING = SER_DLY + SER_HOLD + 1 + P_GAP;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        tbl_we;
    logic [3:0]  tbl_addr;
    logic [23:0] tbl_wdata;
    logic [4:0]  cfg_num;
    logic        spi_busy;
    logic        adc_rstn_out;
    logic [23:0] ctrl_word;
    logic        ctrl_load;
    logic        busy;
    logic        done;
    logic        err;

    adc_init_seq #(
        .RST_PULSE_CYC(P_RST),
        .RST_WAIT_CYC (P_WAIT),
        .WORD_GAP_CYC (P_GAP),
        .TIMEOUT_CYC  (P_TO)
    ) dut (
        .adc_set_clk (clk),
        .rstn        (rstn),
        .start       (start),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_wdata   (tbl_wdata),
        .cfg_num     (cfg_num),
        .spi_busy    (spi_busy),
        .adc_rstn_out(adc_rstn_out),
        .ctrl_word   (ctrl_word),
        .ctrl_load   (ctrl_load),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    logic [23:0] tbl_model [16];
    logic [23:0] load_words[$];
    int          load_cycs[$];
    int          done_cnt;
    int          done_cyc;
    int          rst_lo_cnt;
    int          rst_lo_first;
    int          start_cyc;
    int          idle_cyc;
    bit          ser_en;

    typedef struct {
        logic [4:0] cfg;
        int         exp_loads;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: samples DUT outputs mid-cycle.
    always @(negedge clk) begin
        if (ctrl_load === 1'b1) begin
            load_words.push_back(ctrl_word);
            load_cycs.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (adc_rstn_out === 1'b0) begin
            if (rst_lo_cnt == 0) rst_lo_first = cyc;
            rst_lo_cnt++;
        end
    end

    // Serializer model.
    initial begin
        spi_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (ser_en && ctrl_load === 1'b1) begin
                repeat (SER_DLY) @(negedge clk);
                spi_busy = 1'b1;
                repeat (SER_HOLD) @(negedge clk);
                spi_busy = 1'b0;
            end
        end
    end

    task automatic tbl_write(input logic [3:0] a, input logic [23:0] d);
        @(negedge clk);
        tbl_we    = 1'b1;
        tbl_addr  = a;
        tbl_wdata = d;
        @(negedge clk);
        tbl_we    = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] n);
        @(negedge clk);
        load_words.delete();
        load_cycs.delete();
        done_cnt   = 0;
        done_cyc   = -1;
        rst_lo_cnt = 0;
        rst_lo_first = -1;
        cfg_num   = n;
        start     = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        idle_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                idle_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_run(input string tag, input int exp_loads);
        int nl;
        int exp_done;
        nl = load_words.size();
        exp_done = start_cyc + FIRST + exp_loads * SPACING;
        check({tag, "_rst_lo_cycles"}, rst_lo_cnt, P_RST);
        check({tag, "_rst_lo_first"}, rst_lo_first, start_cyc);
        check({tag, "_load_count"}, nl, exp_loads);
        for (int i = 0; i < nl && i < exp_loads; i++) begin
            check($sformatf("%s_word%0d", tag, i), load_words[i], tbl_model[i]);
            check($sformatf("%s_load%0d_cycle", tag, i), load_cycs[i], start_cyc + FIRST + i * SPACING);
        end
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_idle_cycle"}, idle_cyc, exp_done + 1);
        check({tag, "_err"}, err, 1'b0);
        if (exp_loads > 0)
            check({tag, "_word_held"}, ctrl_word, tbl_model[exp_loads-1]);
    endtask

    initial begin
        bit ok;

        vecs[0] = '{cfg: 5'd3,  exp_loads: 3};
        vecs[1] = '{cfg: 5'd0,  exp_loads: 0};
        vecs[2] = '{cfg: 5'd1,  exp_loads: 1};
        vecs[3] = '{cfg: 5'd20, exp_loads: 16};
        vecs[4] = '{cfg: 5'd16, exp_loads: 16};

        rstn      = 1'b0;
        start     = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = '0;
        cfg_num   = '0;
        ser_en    = 1'b1;
        done_cnt  = 0;
        rst_lo_cnt = 0;

        repeat (3) @(negedge clk);
        check("reset_adc_rstn_out", adc_rstn_out, 1'b1);
        check("reset_ctrl_word", ctrl_word, 24'h0);
        check("reset_ctrl_load", ctrl_load, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       tbl_model[i] = 24'h000001;
                1:       tbl_model[i] = 24'h011234;
                2:       tbl_model[i] = 24'h7FFFFF;
                default: tbl_model[i] = 24'h800000 | (24'(i) << 16) | 24'(i * 257);
            endcase
            tbl_write(4'(i), tbl_model[i]);
        end

        // Main sweep over word counts, including zero and the clamp.
        for (int v = 0; v < 5; v++) begin
            start_run(vecs[v].cfg);
            wait_idle(2000, ok);
            check($sformatf("vec%0d_finished", v), ok, 1'b1);
            check_run($sformatf("vec%0d", v), vecs[v].exp_loads);
        end

        // Serializer never responds: timeout in WAIT_HI.
        ser_en = 1'b0;
        start_run(5'd3);
        wait_idle(500, ok);
        check("to_finished", ok, 1'b1);
        check("to_idle_cycle", idle_cyc, start_cyc + FIRST + 1 + P_TO);
        check("to_err", err, 1'b1);
        check("to_done_count", done_cnt, 0);
        check("to_load_count", load_words.size(), 1);
        ser_en = 1'b1;
        start_run(5'd3);
        check("to_err_cleared", err, 1'b0);
        check("to_rerun_busy", busy, 1'b1);
        wait_idle(2000, ok);
        check("to_rerun_finished", ok, 1'b1);
        check_run("to_rerun", 3);

        // Table write while busy is dropped; the same write in IDLE lands.
        start_run(5'd3);
        repeat (5) @(negedge clk);
        tbl_write(4'd2, 24'hABCDEF);
        wait_idle(2000, ok);
        check("wr_busy_finished", ok, 1'b1);
        check_run("wr_busy", 3);
        tbl_write(4'd2, 24'hABCDEF);
        tbl_model[2] = 24'hABCDEF;
        start_run(5'd3);
        wait_idle(2000, ok);
        check("wr_idle_finished", ok, 1'b1);
        check_run("wr_idle", 3);

        // Asynchronous reset during WAIT_LO of word 1.
        start_run(5'd3);
        for (int i = 0; i < 500 && load_words.size() < 2; i++) @(negedge clk);
        check("rst_reached_word1", load_words.size() >= 2, 1'b1);
        repeat (6) @(negedge clk);
        check("rst_in_wait_lo", spi_busy, 1'b1);
        rstn = 1'b0;
        #1;
        check("rst_adc_rstn_out", adc_rstn_out, 1'b1);
        check("rst_ctrl_load", ctrl_load, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ctrl_word", ctrl_word, 24'h0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        start_run(5'd3);
        wait_idle(2000, ok);
        check("rst_rerun_finished", ok, 1'b1);
        check_run("rst_rerun", 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
